// File: rtl/pmt_reg_cmd_slave.sv
// PMT register-command slave: parses two-word command frames from the master
// link, issues one local register write or read per frame, and returns read
// data as a two-word response frame. Protocol violations feed saturating
// error counters.
module pmt_reg_cmd_slave #(
  parameter int unsigned RD_TIMEOUT = 64,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic                 clk_100m,
  input  logic                 rst_100m,
  input  logic [31:0]          pmt_master_wr_data,
  input  logic [1:0]           pmt_master_wr_vld,
  output logic                 reg_wr_en,
  output logic                 reg_rd_en,
  output logic [15:0]          reg_addr,
  output logic [31:0]          reg_wr_data,
  input  logic [31:0]          reg_rd_data,
  input  logic                 reg_rd_vld,
  output logic [31:0]          pmt_slave_rd_data,
  output logic [1:0]           pmt_slave_rd_vld,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_hdr_cnt,
  output logic [ERR_CNT_W-1:0] err_seq_cnt,
  output logic [ERR_CNT_W-1:0] err_tmo_cnt
);

  localparam int unsigned TMR_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [7:0]  MAGIC = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_WAIT,
    ST_RESP_H,
    ST_RESP_D
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          addr_q, addr_d;
  logic                 cmd_q, cmd_d;
  logic                 reg_wr_en_q, reg_wr_en_d;
  logic                 reg_rd_en_q, reg_rd_en_d;
  logic [15:0]          reg_addr_q, reg_addr_d;
  logic [31:0]          reg_wr_data_q, reg_wr_data_d;
  logic [31:0]          rd_cap_q, rd_cap_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [31:0]          slv_data_q, slv_data_d;
  logic [1:0]           slv_vld_q, slv_vld_d;
  logic                 busy_q, busy_d;
  logic [ERR_CNT_W-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [ERR_CNT_W-1:0] seq_cnt_q, seq_cnt_d;
  logic [ERR_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic is_hdr;
  logic is_data;
  logic hdr_ok;
  logic hdr_inc;
  logic seq_inc;
  logic tmo_inc;

  // Word classification; 2'b10 and 2'b00 carry no word.
  always_comb begin
    is_hdr  = (pmt_master_wr_vld == 2'b11);
    is_data = (pmt_master_wr_vld == 2'b01);
    hdr_ok  = (pmt_master_wr_data[15:8] == MAGIC) && (pmt_master_wr_data[6:0] == 7'h0);
  end

  // Frame parser, register strobes, response sequencing and error events.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cmd_d         = cmd_q;
    reg_wr_en_d   = 1'b0;
    reg_rd_en_d   = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    rd_cap_d      = rd_cap_q;
    timer_d       = timer_q;
    slv_data_d    = 32'h0;
    slv_vld_d     = 2'b00;
    hdr_inc       = 1'b0;
    seq_inc       = 1'b0;
    tmo_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_hdr) begin
          if (hdr_ok) begin
            addr_d  = pmt_master_wr_data[31:16];
            cmd_d   = pmt_master_wr_data[7];
            state_d = ST_HDR;
          end else begin
            hdr_inc = 1'b1;
          end
        end else if (is_data) begin
          seq_inc = 1'b1;
        end
      end

      ST_HDR: begin
        if (is_hdr) begin
          // Second header drops the pending frame; a good one restarts it.
          hdr_inc = 1'b1;
          if (hdr_ok) begin
            addr_d = pmt_master_wr_data[31:16];
            cmd_d  = pmt_master_wr_data[7];
          end else begin
            state_d = ST_IDLE;
          end
        end else if (is_data) begin
          reg_addr_d = addr_q;
          if (!cmd_q) begin
            reg_wr_en_d   = 1'b1;
            reg_wr_data_d = pmt_master_wr_data;
            state_d       = ST_IDLE;
          end else begin
            reg_rd_en_d = 1'b1;
            timer_d     = '0;
            state_d     = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        if (is_hdr) begin
          hdr_inc = 1'b1;
        end else if (is_data) begin
          seq_inc = 1'b1;
        end
        if (reg_rd_vld) begin
          rd_cap_d   = reg_rd_data;
          slv_vld_d  = 2'b11;
          slv_data_d = {addr_q, MAGIC, 1'b1, 7'h0};
          state_d    = ST_RESP_H;
        end else if (timer_q == TMR_W'(RD_TIMEOUT - 1)) begin
          tmo_inc = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_RESP_H: begin
        if (is_hdr) begin
          hdr_inc = 1'b1;
        end else if (is_data) begin
          seq_inc = 1'b1;
        end
        slv_vld_d  = 2'b01;
        slv_data_d = rd_cap_q;
        state_d    = ST_RESP_D;
      end

      ST_RESP_D: begin
        if (is_hdr) begin
          hdr_inc = 1'b1;
        end else if (is_data) begin
          seq_inc = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Saturating error counters.
  always_comb begin
    hdr_cnt_d = (hdr_inc && (hdr_cnt_q != '1)) ? hdr_cnt_q + ERR_CNT_W'(1) : hdr_cnt_q;
    seq_cnt_d = (seq_inc && (seq_cnt_q != '1)) ? seq_cnt_q + ERR_CNT_W'(1) : seq_cnt_q;
    tmo_cnt_d = (tmo_inc && (tmo_cnt_q != '1)) ? tmo_cnt_q + ERR_CNT_W'(1) : tmo_cnt_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      cmd_q         <= 1'b0;
      reg_wr_en_q   <= 1'b0;
      reg_rd_en_q   <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      rd_cap_q      <= '0;
      timer_q       <= '0;
      slv_data_q    <= '0;
      slv_vld_q     <= 2'b00;
      busy_q        <= 1'b0;
      hdr_cnt_q     <= '0;
      seq_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cmd_q         <= cmd_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_rd_en_q   <= reg_rd_en_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      rd_cap_q      <= rd_cap_d;
      timer_q       <= timer_d;
      slv_data_q    <= slv_data_d;
      slv_vld_q     <= slv_vld_d;
      busy_q        <= busy_d;
      hdr_cnt_q     <= hdr_cnt_d;
      seq_cnt_q     <= seq_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign reg_wr_en         = reg_wr_en_q;
  assign reg_rd_en         = reg_rd_en_q;
  assign reg_addr          = reg_addr_q;
  assign reg_wr_data       = reg_wr_data_q;
  assign pmt_slave_rd_data = slv_data_q;
  assign pmt_slave_rd_vld  = slv_vld_q;
  assign busy              = busy_q;
  assign err_hdr_cnt       = hdr_cnt_q;
  assign err_seq_cnt       = seq_cnt_q;
  assign err_tmo_cnt       = tmo_cnt_q;

endmodule

// File: tb/tb_pmt_reg_cmd_slave.sv
// Bench for pmt_reg_cmd_slave: a frame-level reference model pushes expected
// register strobes and response frames into queues; a monitor pops and
// compares whenever the DUT presents a strobe or response word.
module tb_pmt_reg_cmd_slave;

  localparam int unsigned RD_TIMEOUT = 64;
  localparam int unsigned ERR_W      = 5;
  localparam int          MAXC       = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      wr_data;
  logic [1:0]       wr_vld;
  logic             reg_wr_en, reg_rd_en;
  logic [15:0]      reg_addr;
  logic [31:0]      reg_wr_data, rd_data;
  logic             rd_vld;
  logic [31:0]      slv_data;
  logic [1:0]       slv_vld;
  logic             busy;
  logic [ERR_W-1:0] err_hdr, err_seq, err_tmo;

  pmt_reg_cmd_slave #(.RD_TIMEOUT(RD_TIMEOUT), .ERR_CNT_W(ERR_W)) dut (
    .clk_100m(clk), .rst_100m(rst),
    .pmt_master_wr_data(wr_data), .pmt_master_wr_vld(wr_vld),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(rd_data), .reg_rd_vld(rd_vld),
    .pmt_slave_rd_data(slv_data), .pmt_slave_rd_vld(slv_vld), .busy(busy),
    .err_hdr_cnt(err_hdr), .err_seq_cnt(err_seq), .err_tmo_cnt(err_tmo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected traffic: writes {addr,data}, read strobes {addr}, responses {hdr,data}.
  logic [47:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic [63:0] exp_resp_q[$];

  // Frame-level model state.
  bit          m_pend;
  logic [15:0] m_addr;
  bit          m_cmd;
  bit          m_rd_pend;
  logic [15:0] m_rd_addr;
  int          m_hdr, m_seq, m_tmo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  function automatic logic [31:0] good_hdr(input logic [15:0] a, input bit rd);
    return {a, 8'h01, rd, 7'h0};
  endfunction

  function automatic logic [31:0] bad_hdr();
    logic [31:0] w;
    w = $urandom;
    if (w[15:8] == 8'h01 && w[6:0] == 7'h0) w[15:8] = 8'h02;
    return w;
  endfunction

  // Reference rules: a header is good iff magic byte matches and low bits clear.
  function automatic void model_word(input logic [31:0] w, input bit is_hdr);
    bit ok;
    if (is_hdr) begin
      ok = (w[15:8] == 8'h01) && (w[6:0] == 7'h0);
      if (m_pend || !ok) m_hdr++;
      m_pend = ok;
      if (ok) begin
        m_addr = w[31:16];
        m_cmd  = w[7];
      end
    end else if (!m_pend) begin
      m_seq++;
    end else begin
      m_pend = 0;
      if (!m_cmd) exp_wr_q.push_back({m_addr, w});
      else begin
        exp_rd_q.push_back(m_addr);
        m_rd_pend = 1;
        m_rd_addr = m_addr;
      end
    end
  endfunction

  task automatic drive(input logic [31:0] w, input logic [1:0] v);
    wr_data = w;
    wr_vld  = v;
    @(posedge clk); #1;
    wr_vld  = 2'b00;
    wr_data = $urandom;
  endtask

  task automatic send_hdr(input logic [31:0] w);
    model_word(w, 1'b1);
    drive(w, 2'b11);
  endtask

  task automatic send_data(input logic [31:0] w);
    model_word(w, 1'b0);
    drive(w, 2'b01);
  endtask

  task automatic junk_cycle();
    drive($urandom, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_pend = 0; m_rd_pend = 0;
    m_hdr = 0; m_seq = 0; m_tmo = 0;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_err_hdr"}, 64'(err_hdr), 64'(sat(m_hdr)));
    check({tag, "_err_seq"}, 64'(err_seq), 64'(sat(m_seq)));
    check({tag, "_err_tmo"}, 64'(err_tmo), 64'(sat(m_tmo)));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_drop", 64'(busy), 64'(0));
  endtask

  // Answers the read strobe just issued: data after d cycles, or never.
  task automatic do_read(input bit tmo, input int d, input bit stray, input logic [31:0] rdat);
    int n;
    bit sh;
    m_rd_pend = 0;
    if (tmo) begin
      m_tmo++;
      n = 0;
      while (busy && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      check("tmo_cycles", 64'(n), 64'(RD_TIMEOUT));
    end else begin
      for (int c = 0; c < d; c++) begin
        if (c == 0 && stray) begin
          sh = ($urandom_range(0, 1) != 0);
          if (sh) m_hdr++; else m_seq++;
          drive($urandom, sh ? 2'b11 : 2'b01);
        end else begin
          @(posedge clk); #1;
        end
      end
      exp_resp_q.push_back({good_hdr(m_rd_addr, 1'b1), rdat});
      rd_data = rdat;
      rd_vld  = 1'b1;
      @(posedge clk); #1;
      rd_vld  = 1'b0;
      rd_data = $urandom;
      check("resp_hdr_latency", 64'(slv_vld), 64'(2'b11));
      wait_idle();
    end
  endtask

  // Monitor: compares every strobe and response word against the queues.
  initial begin
    bit          pend_d = 0;
    logic [31:0] exp_d  = '0;
    logic [63:0] r;
    logic [47:0] wexp;
    logic [15:0] rexp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (reg_wr_en) begin
          check("wr_expected", 64'(exp_wr_q.size() != 0), 64'(1));
          if (exp_wr_q.size() != 0) begin
            wexp = exp_wr_q.pop_front();
            check("wr_addr", 64'(reg_addr), 64'(wexp[47:32]));
            check("wr_data", 64'(reg_wr_data), 64'(wexp[31:0]));
          end
        end
        if (reg_rd_en) begin
          check("rd_expected", 64'(exp_rd_q.size() != 0), 64'(1));
          if (exp_rd_q.size() != 0) begin
            rexp = exp_rd_q.pop_front();
            check("rd_addr", 64'(reg_addr), 64'(rexp));
          end
        end
        if (pend_d) begin
          check("resp_vld_data", 64'(slv_vld), 64'(2'b01));
          check("resp_data", 64'(slv_data), 64'(exp_d));
          pend_d = 0;
        end else if (slv_vld == 2'b11) begin
          check("resp_expected", 64'(exp_resp_q.size() != 0), 64'(1));
          if (exp_resp_q.size() != 0) begin
            r = exp_resp_q.pop_front();
            check("resp_hdr", 64'(slv_data), 64'(r[63:32]));
            exp_d  = r[31:0];
            pend_d = 1;
          end
        end else if (slv_vld != 2'b00) begin
          check("resp_vld_stray", 64'(slv_vld), 64'(0));
        end
      end
    end
  end

  initial begin
    int kind;
    bit rd;
    rst = 1'b1; wr_data = '0; wr_vld = 2'b00; rd_data = '0; rd_vld = 1'b0;
    do_reset();

    check("rst_wr_en", 64'(reg_wr_en), 64'(0));
    check("rst_rd_en", 64'(reg_rd_en), 64'(0));
    check("rst_addr", 64'(reg_addr), 64'(0));
    check("rst_wr_data", 64'(reg_wr_data), 64'(0));
    check("rst_slv", 64'({slv_vld, slv_data}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check_cnts("rst");

    // Simple write.
    send_hdr(32'h0014_0100);
    check("busy_in_hdr", 64'(busy), 64'(1));
    send_data(32'h0000_0001);
    check("wr_en_latency", 64'(reg_wr_en), 64'(1));
    @(posedge clk); #1;
    check("wr_en_single", 64'(reg_wr_en), 64'(0));
    check("addr_hold", 64'(reg_addr), 64'(16'h0014));
    check_cnts("t1");

    // Read answered three cycles later.
    do_reset();
    send_hdr(32'h0020_0180);
    send_data(32'h0);
    check("rd_en_latency", 64'(reg_rd_en), 64'(1));
    do_read(1'b0, 3, 1'b0, 32'hDEAD_BEEF);
    check_cnts("t2");

    // Bad magic followed by orphan data.
    do_reset();
    send_hdr(32'h0014_0200);
    send_data(32'h0000_0001);
    repeat (2) @(posedge clk); #1;
    check_cnts("t3");

    // Read never answered.
    do_reset();
    send_hdr(32'h0040_0180);
    send_data(32'h0);
    do_read(1'b1, 0, 1'b0, 32'h0);
    repeat (3) @(posedge clk); #1;
    check_cnts("t4");

    // Header restarted by a second header.
    do_reset();
    send_hdr(32'h0010_0100);
    send_hdr(32'h0030_0100);
    send_data(32'h0000_0005);
    @(posedge clk); #1;
    check_cnts("t5");

    // Reset between header and data.
    do_reset();
    send_hdr(32'h0050_0100);
    do_reset();
    send_hdr(32'h0040_0100);
    send_data(32'h0000_1234);
    @(posedge clk); #1;
    check_cnts("t6");

    // Randomized frame mix.
    do_reset();
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: begin
          rd = ($urandom_range(0, 9) < 4);
          send_hdr(good_hdr(16'($urandom), rd));
          repeat ($urandom_range(0, 2)) junk_cycle();
          send_data($urandom);
        end
        4: begin
          send_hdr(bad_hdr());
          if ($urandom_range(0, 1) != 0) send_data($urandom);
        end
        5: send_data($urandom);
        6: begin
          send_hdr(($urandom_range(0, 1) != 0) ? bad_hdr() : good_hdr(16'($urandom), 1'b0));
          send_hdr(good_hdr(16'($urandom), $urandom_range(0, 1) != 0));
          send_data($urandom);
        end
        7: begin
          rd_data = $urandom;
          rd_vld  = 1'b1;
          @(posedge clk); #1;
          rd_vld  = 1'b0;
        end
        default: begin
          send_hdr(good_hdr(16'($urandom), 1'b0));
          send_data($urandom);
        end
      endcase
      if (m_rd_pend) begin
        if ($urandom_range(0, 7) == 0) do_read(1'b1, 0, 1'b0, 32'h0);
        else do_read(1'b0, $urandom_range(1, 6), $urandom_range(0, 1) != 0, $urandom);
      end
      if (m_pend && $urandom_range(0, 3) == 0) begin
        send_data($urandom);
        if (m_rd_pend) do_read(1'b0, $urandom_range(1, 4), 1'b0, $urandom);
      end
      repeat ($urandom_range(0, 2)) junk_cycle();
    end
    repeat (4) @(posedge clk); #1;
    check_cnts("rand");

    // Counter saturation.
    do_reset();
    repeat (40) send_data($urandom);
    repeat (40) send_hdr(bad_hdr());
    for (int i = 0; i < MAXC + 2; i++) begin
      send_hdr(good_hdr(16'($urandom), 1'b1));
      send_data($urandom);
      do_read(1'b1, 0, 1'b0, 32'h0);
    end
    @(posedge clk); #1;
    check_cnts("sat");
    check("sat_hdr_ones", 64'(err_hdr), 64'(MAXC));

    repeat (4) @(posedge clk); #1;
    check("wr_q_drained", 64'(exp_wr_q.size()), 64'(0));
    check("rd_q_drained", 64'(exp_rd_q.size()), 64'(0));
    check("resp_q_drained", 64'(exp_resp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
